// File: rtl/mips_pipe_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_pipe_core: 5-stage MIPS pipeline with switchable EX forwarding,     |
// | interlocks, branch/jump flush and a WB retire port.  Revision: 1.0        |
// +--------------------------------------------------------------------------+
module mips_pipe_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FORWARDING = 1,
  parameter int          ADDR_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [31:0]       dmem_rdata,
  output logic              retire_valid,
  output logic [31:0]       retire_pc,
  output logic              retire_wen,
  output logic [4:0]        retire_waddr,
  output logic [31:0]       retire_wdata
);

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_and   = 6'h24;
  localparam logic [5:0] c_fn_or    = 6'h25;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [2:0] c_alu_add  = 3'd0;
  localparam logic [2:0] c_alu_sub  = 3'd1;
  localparam logic [2:0] c_alu_and  = 3'd2;
  localparam logic [2:0] c_alu_or   = 3'd3;
  localparam logic [2:0] c_alu_slt  = 3'd4;

  logic [31:0] r_pc;
  logic        r_ifid_valid;
  logic [31:0] r_ifid_pc, r_ifid_instr;

  logic        r_idex_valid, r_idex_wen, r_idex_use_imm, r_idex_lw, r_idex_sw, r_idex_beq;
  logic [31:0] r_idex_pc, r_idex_a, r_idex_b, r_idex_imm;
  logic [4:0]  r_idex_rs, r_idex_rt, r_idex_dest;
  logic [2:0]  r_idex_alu;

  logic        r_exmem_valid, r_exmem_wen, r_exmem_lw, r_exmem_sw;
  logic [31:0] r_exmem_pc, r_exmem_alu, r_exmem_store;
  logic [4:0]  r_exmem_dest;

  logic        r_memwb_valid, r_memwb_wen;
  logic [31:0] r_memwb_pc, r_memwb_wdata;
  logic [4:0]  r_memwb_dest;

  logic [31:0] r_rf [32];

  // ---------------- ID: decode and register read ----------------
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_imm_sext;
  logic        w_dec_wen, w_dec_use_imm, w_dec_lw, w_dec_sw, w_dec_beq, w_dec_j;
  logic        w_use_rs, w_use_rt;
  logic [4:0]  w_dec_dest;
  logic [2:0]  w_dec_alu;

  assign w_op       = r_ifid_instr[31:26];
  assign w_rs       = r_ifid_instr[25:21];
  assign w_rt       = r_ifid_instr[20:16];
  assign w_rd       = r_ifid_instr[15:11];
  assign w_shamt    = r_ifid_instr[10:6];
  assign w_funct    = r_ifid_instr[5:0];
  assign w_imm_sext = {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

  always_comb begin
    w_dec_wen     = 1'b0;
    w_dec_dest    = 5'd0;
    w_dec_alu     = c_alu_add;
    w_dec_use_imm = 1'b0;
    w_dec_lw      = 1'b0;
    w_dec_sw      = 1'b0;
    w_dec_beq     = 1'b0;
    w_dec_j       = 1'b0;
    w_use_rs      = 1'b0;
    w_use_rt      = 1'b0;
    case (w_op)
      c_op_rtype: begin
        if (w_shamt == 5'd0) begin
          w_use_rs   = 1'b1;
          w_use_rt   = 1'b1;
          w_dec_wen  = 1'b1;
          w_dec_dest = w_rd;
          case (w_funct)
            c_fn_add: w_dec_alu = c_alu_add;
            c_fn_sub: w_dec_alu = c_alu_sub;
            c_fn_and: w_dec_alu = c_alu_and;
            c_fn_or:  w_dec_alu = c_alu_or;
            c_fn_slt: w_dec_alu = c_alu_slt;
            default: begin
              w_use_rs   = 1'b0;
              w_use_rt   = 1'b0;
              w_dec_wen  = 1'b0;
              w_dec_dest = 5'd0;
            end
          endcase
        end
      end
      c_op_addi: begin
        w_use_rs = 1'b1; w_dec_wen = 1'b1; w_dec_dest = w_rt; w_dec_use_imm = 1'b1;
      end
      c_op_lw: begin
        w_use_rs = 1'b1; w_dec_wen = 1'b1; w_dec_dest = w_rt; w_dec_use_imm = 1'b1;
        w_dec_lw = 1'b1;
      end
      c_op_sw: begin
        w_use_rs = 1'b1; w_use_rt = 1'b1; w_dec_use_imm = 1'b1; w_dec_sw = 1'b1;
      end
      c_op_beq: begin
        w_use_rs = 1'b1; w_use_rt = 1'b1; w_dec_beq = 1'b1;
      end
      c_op_j:  w_dec_j = 1'b1;
      default: w_dec_j = 1'b0;
    endcase
    // r0 destinations never write, so downstream logic only needs to test wen
    if (w_dec_dest == 5'd0) w_dec_wen = 1'b0;
  end

  logic        w_wb_write;
  logic [31:0] w_rs_val, w_rt_val;
  assign w_wb_write = r_memwb_valid & r_memwb_wen;

  always_comb begin
    w_rs_val = r_rf[w_rs];
    if (w_rs == 5'd0) w_rs_val = '0;
    else if (w_wb_write && (r_memwb_dest == w_rs)) w_rs_val = r_memwb_wdata;
    w_rt_val = r_rf[w_rt];
    if (w_rt == 5'd0) w_rt_val = '0;
    else if (w_wb_write && (r_memwb_dest == w_rt)) w_rt_val = r_memwb_wdata;
  end

  // PC+4 only carries into bit 28 when PC[27:2] is all ones
  logic [3:0]  w_j_hi;
  logic [31:0] w_j_target;
  logic        w_jump;
  assign w_j_hi     = r_ifid_pc[31:28] + {3'd0, &r_ifid_pc[27:2]};
  assign w_j_target = {w_j_hi, r_ifid_instr[25:0], 2'b00};
  assign w_jump     = r_ifid_valid & w_dec_j;

  // ---------------- Hazards and EX operand selection ----------------
  logic        w_stall;
  logic [31:0] w_ex_a, w_ex_b;

  generate
    if (FORWARDING != 0) begin : g_fwd
      assign w_stall = r_ifid_valid & r_idex_valid & r_idex_lw &
                       ((w_use_rs & (r_idex_rt == w_rs)) | (w_use_rt & (r_idex_rt == w_rt)));
      always_comb begin
        w_ex_a = r_idex_a;
        if (r_exmem_valid && r_exmem_wen && !r_exmem_lw && (r_exmem_dest == r_idex_rs))
          w_ex_a = r_exmem_alu;
        else if (w_wb_write && (r_memwb_dest == r_idex_rs))
          w_ex_a = r_memwb_wdata;
        w_ex_b = r_idex_b;
        if (r_exmem_valid && r_exmem_wen && !r_exmem_lw && (r_exmem_dest == r_idex_rt))
          w_ex_b = r_exmem_alu;
        else if (w_wb_write && (r_memwb_dest == r_idex_rt))
          w_ex_b = r_memwb_wdata;
      end
    end else begin : g_nofwd
      logic w_hz_ex, w_hz_mem;
      assign w_hz_ex  = r_idex_valid & r_idex_wen &
                        ((w_use_rs & (r_idex_dest == w_rs)) | (w_use_rt & (r_idex_dest == w_rt)));
      assign w_hz_mem = r_exmem_valid & r_exmem_wen &
                        ((w_use_rs & (r_exmem_dest == w_rs)) | (w_use_rt & (r_exmem_dest == w_rt)));
      assign w_stall  = r_ifid_valid & (w_hz_ex | w_hz_mem);
      assign w_ex_a   = r_idex_a;
      assign w_ex_b   = r_idex_b;
    end
  endgenerate

  // ---------------- EX ----------------
  logic [31:0] w_ex_opb, w_alu, w_br_target;
  logic        w_br_taken;
  assign w_ex_opb = r_idex_use_imm ? r_idex_imm : w_ex_b;

  always_comb begin
    case (r_idex_alu)
      c_alu_sub: w_alu = w_ex_a - w_ex_opb;
      c_alu_and: w_alu = w_ex_a & w_ex_opb;
      c_alu_or:  w_alu = w_ex_a | w_ex_opb;
      c_alu_slt: w_alu = {31'd0, ($signed(w_ex_a) < $signed(w_ex_opb))};
      default:   w_alu = w_ex_a + w_ex_opb;
    endcase
  end

  assign w_br_taken  = r_idex_valid & r_idex_beq & (w_ex_a == w_ex_b);
  assign w_br_target = r_idex_pc + 32'd4 + {r_idex_imm[29:0], 2'b00};

  logic [31:0] w_mem_wdata;
  assign w_mem_wdata = r_exmem_lw ? dmem_rdata : r_exmem_alu;

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_ifid_valid  <= 1'b0;
      r_ifid_pc     <= '0;
      r_ifid_instr  <= '0;
      r_idex_valid  <= 1'b0;
      r_idex_wen    <= 1'b0;
      r_idex_use_imm <= 1'b0;
      r_idex_lw     <= 1'b0;
      r_idex_sw     <= 1'b0;
      r_idex_beq    <= 1'b0;
      r_idex_pc     <= '0;
      r_idex_a      <= '0;
      r_idex_b      <= '0;
      r_idex_imm    <= '0;
      r_idex_rs     <= '0;
      r_idex_rt     <= '0;
      r_idex_dest   <= '0;
      r_idex_alu    <= c_alu_add;
      r_exmem_valid <= 1'b0;
      r_exmem_wen   <= 1'b0;
      r_exmem_lw    <= 1'b0;
      r_exmem_sw    <= 1'b0;
      r_exmem_pc    <= '0;
      r_exmem_alu   <= '0;
      r_exmem_store <= '0;
      r_exmem_dest  <= '0;
      r_memwb_valid <= 1'b0;
      r_memwb_wen   <= 1'b0;
      r_memwb_pc    <= '0;
      r_memwb_wdata <= '0;
      r_memwb_dest  <= '0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      // taken branch flush > interlock hold > jump redirect > sequential fetch
      if (w_br_taken) begin
        r_pc         <= w_br_target;
        r_ifid_valid <= 1'b0;
      end else if (w_stall) begin
        r_pc         <= r_pc;
      end else if (w_jump) begin
        r_pc         <= w_j_target;
        r_ifid_valid <= 1'b0;
      end else begin
        r_pc         <= r_pc + 32'd4;
        r_ifid_valid <= 1'b1;
        r_ifid_pc    <= r_pc;
        r_ifid_instr <= imem_rdata;
      end

      r_idex_valid   <= r_ifid_valid & ~w_br_taken & ~w_stall;
      r_idex_wen     <= w_dec_wen;
      r_idex_use_imm <= w_dec_use_imm;
      r_idex_lw      <= w_dec_lw;
      r_idex_sw      <= w_dec_sw;
      r_idex_beq     <= w_dec_beq;
      r_idex_pc      <= r_ifid_pc;
      r_idex_a       <= w_rs_val;
      r_idex_b       <= w_rt_val;
      r_idex_imm     <= w_imm_sext;
      r_idex_rs      <= w_rs;
      r_idex_rt      <= w_rt;
      r_idex_dest    <= w_dec_dest;
      r_idex_alu     <= w_dec_alu;

      r_exmem_valid  <= r_idex_valid;
      r_exmem_wen    <= r_idex_wen;
      r_exmem_lw     <= r_idex_lw;
      r_exmem_sw     <= r_idex_sw;
      r_exmem_pc     <= r_idex_pc;
      r_exmem_alu    <= w_alu;
      r_exmem_store  <= w_ex_b;
      r_exmem_dest   <= r_idex_dest;

      r_memwb_valid  <= r_exmem_valid;
      r_memwb_wen    <= r_exmem_wen;
      r_memwb_pc     <= r_exmem_pc;
      r_memwb_wdata  <= r_exmem_wen ? w_mem_wdata : '0;
      r_memwb_dest   <= r_exmem_dest;

      if (w_wb_write) r_rf[r_memwb_dest] <= r_memwb_wdata;
    end
  end

  assign imem_addr    = r_pc[ADDR_W-1:0];
  assign dmem_addr    = r_exmem_alu[ADDR_W-1:0];
  assign dmem_wdata   = r_exmem_store;
  assign dmem_we      = r_exmem_valid & r_exmem_sw;
  assign dmem_re      = r_exmem_valid & r_exmem_lw;
  assign retire_valid = r_memwb_valid;
  assign retire_pc    = r_memwb_pc;
  assign retire_wen   = r_memwb_valid & r_memwb_wen;
  assign retire_waddr = r_memwb_dest;
  assign retire_wdata = r_memwb_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mips_pipe_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_pipe_core: directed programs on a forwarding and a stalling core. |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mips_pipe_core;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [31:0] imem   [0:255];
  logic [31:0] dmem_a [0:255];
  logic [31:0] dmem_b [0:255];

  logic [31:0] ia_addr, ia_rdata, da_addr, da_wdata, da_rdata, ra_pc, ra_wdata;
  logic        da_we, da_re, ra_valid, ra_wen;
  logic [4:0]  ra_waddr;
  logic [31:0] ib_addr, ib_rdata, db_addr, db_wdata, db_rdata, rb_pc, rb_wdata;
  logic        db_we, db_re, rb_valid, rb_wen;
  logic [4:0]  rb_waddr;

  assign ia_rdata = imem[ia_addr[9:2]];
  assign ib_rdata = imem[ib_addr[9:2]];
  assign da_rdata = dmem_a[da_addr[9:2]];
  assign db_rdata = dmem_b[db_addr[9:2]];

  always @(posedge clock) begin
    if (da_we) dmem_a[da_addr[9:2]] <= da_wdata;
    if (db_we) dmem_b[db_addr[9:2]] <= db_wdata;
  end

  mips_pipe_core #(.RESET_PC(32'h0), .FORWARDING(1), .ADDR_W(32)) u_dut_fwd (
    .clock(clock), .reset(reset),
    .imem_addr(ia_addr), .imem_rdata(ia_rdata),
    .dmem_addr(da_addr), .dmem_wdata(da_wdata), .dmem_we(da_we), .dmem_re(da_re),
    .dmem_rdata(da_rdata),
    .retire_valid(ra_valid), .retire_pc(ra_pc), .retire_wen(ra_wen),
    .retire_waddr(ra_waddr), .retire_wdata(ra_wdata)
  );

  mips_pipe_core #(.RESET_PC(32'h0), .FORWARDING(0), .ADDR_W(32)) u_dut_nofwd (
    .clock(clock), .reset(reset),
    .imem_addr(ib_addr), .imem_rdata(ib_rdata),
    .dmem_addr(db_addr), .dmem_wdata(db_wdata), .dmem_we(db_we), .dmem_re(db_re),
    .dmem_rdata(db_rdata),
    .retire_valid(rb_valid), .retire_pc(rb_pc), .retire_wen(rb_wen),
    .retire_waddr(rb_waddr), .retire_wdata(rb_wdata)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ret_t;
  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  ret_t        qa[$];
  ret_t        qb[$];
  mem_t        ma[$];
  logic [31:0] fa  [0:63];
  logic        rva [0:63];
  logic        rvb [0:63];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] f_r(input logic [5:0] fn, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rt,
                                      input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0; dmem_a[i] = 32'h0; dmem_b[i] = 32'h0;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Cycle 0 is the first cycle after reset release (fetch of RESET_PC).
  task automatic run(input int n);
    qa.delete(); qb.delete(); ma.delete();
    for (int c = 0; c < n; c++) begin
      fa[c]  = ia_addr;
      rva[c] = ra_valid;
      rvb[c] = rb_valid;
      if (ra_valid) qa.push_back('{cyc:c, pc:ra_pc, wen:ra_wen, waddr:ra_waddr, wdata:ra_wdata});
      if (rb_valid) qb.push_back('{cyc:c, pc:rb_pc, wen:rb_wen, waddr:rb_waddr, wdata:rb_wdata});
      if (da_we || da_re) ma.push_back('{cyc:c, we:da_we, addr:da_addr, wdata:da_wdata});
      @(negedge clock);
    end
  endtask

  // waddr==0 means the retirement must not write; cyc<0 skips the timing check
  task automatic chk_ret(input string tag, input bit use_b, input logic [31:0] pc,
                         input int cyc, input logic [4:0] waddr, input logic [31:0] wdata);
    int   idx;
    ret_t r;
    idx = -1;
    if (use_b) begin
      for (int i = qb.size() - 1; i >= 0; i--) if (qb[i].pc == pc) idx = i;
    end else begin
      for (int i = qa.size() - 1; i >= 0; i--) if (qa[i].pc == pc) idx = i;
    end
    if (idx < 0) begin
      chk({tag, "_found"}, 32'd0, 32'd1);
    end else begin
      r = use_b ? qb[idx] : qa[idx];
      if (cyc >= 0) chk({tag, "_cyc"}, r.cyc, cyc);
      chk({tag, "_wen"}, {31'd0, r.wen}, {31'd0, waddr != 5'd0});
      if (waddr != 5'd0) begin
        chk({tag, "_waddr"}, {27'd0, r.waddr}, {27'd0, waddr});
        chk({tag, "_wdata"}, r.wdata, wdata);
      end
    end
  endtask

  task automatic chk_noret(input string tag, input bit use_b, input logic [31:0] pc);
    int cnt;
    cnt = 0;
    if (use_b) begin
      foreach (qb[i]) if (qb[i].pc == pc) cnt++;
    end else begin
      foreach (qa[i]) if (qa[i].pc == pc) cnt++;
    end
    chk(tag, cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- nops: fetch order and first retire latency ----
    clear_mem();
    do_reset();
    run(8);
    chk("fetch0", fa[0], 32'h0);
    chk("fetch1", fa[1], 32'h4);
    chk("fetch2", fa[2], 32'h8);
    chk("rv_c3", {31'd0, rva[3]}, 32'd0);
    chk("rv_c4", {31'd0, rva[4]}, 32'd1);
    chk_ret("nop0", 1'b0, 32'h0, 4, 5'd0, 32'h0);

    // ---- RAW on addi: forwarding vs stalling core ----
    clear_mem();
    imem[0] = f_i(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1] = f_i(6'h08, 5'd2, 5'd1, 16'd3);
    do_reset();
    run(14);
    chk_ret("fw_addi1", 1'b0, 32'h0, 4, 5'd1, 32'd5);
    chk_ret("fw_addi2", 1'b0, 32'h4, 5, 5'd2, 32'd8);
    chk_ret("nf_addi1", 1'b1, 32'h0, 4, 5'd1, 32'd5);
    chk_ret("nf_addi2", 1'b1, 32'h4, 7, 5'd2, 32'd8);
    chk("nf_idle5", {31'd0, rvb[5]}, 32'd0);
    chk("nf_idle6", {31'd0, rvb[6]}, 32'd0);

    // ---- load-use, store forwarding, sw r0 ----
    clear_mem();
    imem[0] = f_i(6'h23, 5'd3, 5'd0, 16'd0);
    imem[1] = f_r(6'h20, 5'd4, 5'd3, 5'd3);
    imem[2] = f_i(6'h2B, 5'd4, 5'd0, 16'd16);
    imem[3] = f_i(6'h2B, 5'd0, 5'd0, 16'd20);
    dmem_a[0] = 32'h1234;
    dmem_b[0] = 32'h1234;
    dmem_a[5] = 32'hDEAD_BEEF;
    do_reset();
    run(24);
    chk_ret("lw_r3", 1'b0, 32'h0, 4, 5'd3, 32'h1234);
    chk_ret("add_r4", 1'b0, 32'h4, 6, 5'd4, 32'h2468);
    chk("mem_n", ma.size(), 3);
    if (ma.size() == 3) begin
      chk("lw_re_cyc", ma[0].cyc, 3);
      chk("lw_re", {31'd0, ma[0].we}, 32'd0);
      chk("lw_addr", ma[0].addr, 32'h0);
      chk("sw_cyc", ma[1].cyc, 6);
      chk("sw_addr", ma[1].addr, 32'd16);
      chk("sw_wdata", ma[1].wdata, 32'h2468);
      chk("sw0_addr", ma[2].addr, 32'd20);
      chk("sw0_wdata", ma[2].wdata, 32'h0);
    end
    chk("dmem16", dmem_a[4], 32'h2468);
    chk("dmem20", dmem_a[5], 32'h0);
    chk_ret("nf_add_r4", 1'b1, 32'h4, -1, 5'd4, 32'h2468);
    chk("nf_dmem16", dmem_b[4], 32'h2468);

    // ---- same program, reset asserted mid-stream ----
    dmem_a[4] = 32'h0;
    do_reset();
    run(5);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rv", {31'd0, ra_valid}, 32'd0);
    chk("mid_we", {31'd0, da_we}, 32'd0);
    chk("mid_pc", ia_addr, 32'h0);
    chk("mid_dmem16", dmem_a[4], 32'h0);
    reset = 1'b0;

    // ---- beq taken and not taken ----
    clear_mem();
    imem[0] = f_i(6'h08, 5'd5, 5'd0, 16'd1);
    imem[2] = f_i(6'h04, 5'd0, 5'd0, 16'd2);
    imem[3] = f_i(6'h08, 5'd6, 5'd0, 16'd7);
    imem[4] = f_i(6'h08, 5'd7, 5'd0, 16'd9);
    imem[5] = f_i(6'h08, 5'd8, 5'd0, 16'd11);
    imem[6] = f_i(6'h04, 5'd0, 5'd5, 16'd5);
    imem[7] = f_i(6'h08, 5'd9, 5'd0, 16'd13);
    do_reset();
    run(16);
    chk("br_fetch", fa[5], 32'd20);
    chk_ret("beq_ret", 1'b0, 32'd8, 6, 5'd0, 32'h0);
    chk_noret("br_sq12", 1'b0, 32'd12);
    chk_noret("br_sq16", 1'b0, 32'd16);
    chk_ret("br_tgt", 1'b0, 32'd20, 9, 5'd8, 32'd11);
    chk_ret("beq_nt", 1'b0, 32'd24, 10, 5'd0, 32'h0);
    chk_ret("nt_next", 1'b0, 32'd28, 11, 5'd9, 32'd13);

    // ---- j ----
    clear_mem();
    imem[1]  = {6'h02, 26'h10};
    imem[2]  = f_i(6'h08, 5'd10, 5'd0, 16'd1);
    imem[16] = f_i(6'h08, 5'd11, 5'd0, 16'd2);
    do_reset();
    run(12);
    chk("j_fetch", fa[3], 32'h40);
    chk_ret("j_ret", 1'b0, 32'h4, 5, 5'd0, 32'h0);
    chk_noret("j_sq8", 1'b0, 32'h8);
    chk_ret("j_tgt", 1'b0, 32'h40, 7, 5'd11, 32'd2);

    // ---- j in ID squashed by taken beq in EX ----
    clear_mem();
    imem[0] = f_i(6'h04, 5'd0, 5'd0, 16'd3);
    imem[1] = {6'h02, 26'h20};
    imem[4] = f_i(6'h08, 5'd12, 5'd0, 16'd3);
    do_reset();
    run(12);
    chk("bj_fetch", fa[3], 32'd16);
    chk_noret("bj_sq_j", 1'b0, 32'h4);
    chk_noret("bj_no80", 1'b0, 32'h80);
    chk_ret("bj_tgt", 1'b0, 32'd16, 7, 5'd12, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_pipe_core.md
Name: mips_pipe_core

Overview:
- Parametrised successor of the single-issue 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Adds EX-stage forwarding (switchable), load-use and RAW interlocks, branch/jump flush, J-type jump, configurable reset PC and address width.
- Instruction and data memories are external; the core exposes memory ports and a WB-stage retire port for checking.
- Register file (32x32, r0 hardwired to 0) is internal.

Parameters:
- RESET_PC, 0, PC value loaded on reset; must be word aligned.
- FORWARDING, 1, 1 = EX/MEM and MEM/WB forwarding into EX; 0 = stall in ID until the producer reaches WB.
- ADDR_W, 32, width of imem_addr/dmem_addr; internal PC arithmetic is 32-bit, outputs take PC[ADDR_W-1:0].

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_W  fetch address = PC
- imem_rdata  in  32  instruction at imem_addr, combinational, same cycle
- dmem_addr  out  ADDR_W  EX/MEM ALU result
- dmem_wdata  out  32  store data (forwarded rt value)
- dmem_we  out  1  store strobe, one cycle per valid sw in MEM
- dmem_re  out  1  load strobe, one cycle per valid lw in MEM
- dmem_rdata  in  32  load data, combinational, same cycle as dmem_re
- retire_valid  out  1  valid instruction in WB this cycle
- retire_pc  out  32  PC of the retiring instruction
- retire_wen  out  1  register write performed (0 if destination is r0)
- retire_waddr  out  5  destination register
- retire_wdata  out  32  value written

Behaviour:
- Supported: R-type add/sub/and/or/slt (funct 0x20/0x22/0x24/0x25/0x2A), addi 0x08 (sign-extended immediate), lw 0x23, sw 0x2B, beq 0x04, j 0x02.
- Unknown opcode or funct: executes as a nop that still retires (retire_valid=1, retire_wen=0). The all-zero word is a retiring nop.
- Every stage register carries a valid bit. Invalid stages assert no writes, strobes or retire.
- Reset (synchronous; overrides stall and flush):
  - PC=RESET_PC; all valid bits 0; all registers 0.
  - dmem_we=0, dmem_re=0, retire_*=0.
  - Reset mid-operation discards all in-flight instructions with no memory or register side effects in the following cycle.
- Latency: instruction fetched in cycle n retires in cycle n+4 when there is no stall or flush. Throughput is 1 instruction per cycle.
- Register file:
  - Written at the clock edge ending WB.
  - ID reads bypass WB write data when addresses match and are nonzero (WB-to-ID bypass).
- FORWARDING=1:
  - EX operands are selected by priority EX/MEM (non-load) > MEM/WB > ID/EX value, applied only when the producer is valid, writes a register, and has destination != 0.
  - Load-use: if the ID/EX instruction is a valid lw with rt equal to ID's rs, or rt when used, stall 1 cycle. PC and IF/ID hold; a bubble is inserted into EX.
  - sw data is also forwarded.
- FORWARDING=0: stall in ID while any valid EX or MEM instruction writes a nonzero register read by ID. The WB-to-ID bypass still applies, giving a 2-bubble RAW penalty.
- beq:
  - Resolved in EX: target = PC+4 + (sext(imm)<<2).
  - If taken: PC<=target, IF/ID and ID/EX invalidated (2 bubbles); the beq itself retires.
  - If not taken: no penalty.
- j:
  - Resolved in ID: PC <= {PC_ID+4[31:28], target26, 2'b00}; IF/ID invalidated (1 bubble).
  - j retires with wen=0.
- Priority in one cycle: reset > EX taken branch > load-use/RAW stall > ID jump > normal PC+4. A jump in ID is squashed by a taken branch in EX. A stall does not block a taken-branch flush.
- Arithmetic: 32-bit wraparound, no overflow traps. slt is signed. PC+4 wraps modulo 2^32.
- Writes to r0 are discarded and r0 always reads 0, including through forwarding paths.

Test Plan:
- Reset, then nops at 0,4,8 → imem_addr=0,4,8 on consecutive cycles. First retire_valid occurs 4 cycles after the first fetch, with retire_pc=0. Asserting reset mid-stream gives retire_valid=0 the next cycle and imem_addr=RESET_PC.
- addi r1,r0,5; addi r2,r1,3 with FORWARDING=1 → retires on consecutive cycles, second has waddr=2, wdata=8. With FORWARDING=0 → exactly 2 idle retire cycles between them, same result.
- lw r3,0(r0) with dmem[0]=0x1234; add r4,r3,r3 → dmem_re=1 with addr 0, one bubble, then retire r4=0x2468.
- sw r4,16(r0) after add r4 → one cycle with dmem_we=1, dmem_addr=16, dmem_wdata=0x2468. Also check sw r0 → wdata=0.
- beq r0,r0,+2 at PC=8 → next fetch 20. Instructions at 12 and 16 never retire. A not-taken beq gives no bubble.
- j 0x10 at PC=4 → fetch 0x40 next. The instruction at 8 is flushed. A j in ID while a taken beq is in EX → branch target wins.
